dmem_port_arbiter: RTL and testbench

//  Shares the single data_mem port between the CPU datapath (MEM stage) and a DMA/debug requester.
//  The CPU has priority and a zero-latency pass-through path.
//  The DMA side uses a valid/ready handshake; its reads return one cycle after acceptance.
//  A starvation counter bounds DMA wait by stalling the CPU for one cycle.

---
 rtl/dmem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the data_mem port between the CPU MEM stage (priority,
//               zero-latency pass-through) and a valid/ready DMA requester,
//               with a starvation counter that forces a one-cycle CPU stall.
//               Optional: define ARB_STATS_EN for grant/stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int DMEM_DEPTH   = 128,
    parameter int ADDR_W       = $clog2(DMEM_DEPTH),
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [31:0]       cpu_rd_dout,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [31:0]       cpu_wr_din,
    input  logic [2:0]        cpu_wr_strb,
    output logic              cpu_stall,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [2:0]        dma_strb,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_din,
    output logic              mem_we,
    output logic [2:0]        mem_wr_strb,
    input  logic [31:0]       mem_rd_dout
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_dma_grants,
    output logic [31:0]       stat_cpu_stalls
`endif
);

    // A zero limit still needs a one-bit counter; it simply never advances.
    localparam int c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] w_starve_nxt;
    logic               w_cpu_busy;
    logic               w_grant;

    assign w_cpu_busy  = cpu_re | cpu_we;
    assign cpu_rd_dout = mem_rd_dout;
    assign dma_rvalid  = (r_state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            dma_rdata    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_grant && !dma_we) begin
                dma_rdata <= mem_rd_dout;
            end
        end
    end

    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_starve_nxt = r_starve_cnt;
        dma_ready    = (r_state == ST_IDLE) &&
                       (!w_cpu_busy || (r_starve_cnt >= c_STARVE_MAX));
        w_grant      = dma_valid && dma_ready;
        cpu_stall    = 1'b0;
        mem_rd_addr  = cpu_rd_addr;
        mem_wr_addr  = cpu_wr_addr;
        mem_wr_din   = cpu_wr_din;
        mem_we       = cpu_we;
        mem_wr_strb  = cpu_wr_strb;

        if (w_grant) begin
            // DMA owns both port halves; the CPU holds its request and retries.
            mem_rd_addr = dma_addr;
            mem_wr_addr = dma_addr;
            mem_wr_din  = dma_wdata;
            mem_we      = dma_we;
            mem_wr_strb = dma_strb;
            cpu_stall   = w_cpu_busy;
            w_state_nxt = dma_we ? ST_IDLE : ST_RESP;
        end

        if (w_grant || !dma_valid) begin
            w_starve_nxt = '0;
        end else if ((r_state == ST_IDLE) && w_cpu_busy &&
                     (r_starve_cnt < c_STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + c_CNT_W'(1);
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dma_grants <= 32'h0;
            stat_cpu_stalls <= 32'h0;
        end else begin
            if (w_grant) begin
                stat_dma_grants <= stat_dma_grants + 32'd1;
            end
            if (cpu_stall) begin
                stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter with a data_mem
//               model and a DMA read-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic [31:0]       cpu_rd_dout;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [31:0]       cpu_wr_din;
    logic [2:0]        cpu_wr_strb;
    logic              cpu_stall;
    logic              dma_valid;
    logic              dma_ready;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic [2:0]        dma_strb;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_din;
    logic              mem_we;
    logic [2:0]        mem_wr_strb;
    logic [31:0]       mem_rd_dout;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_dma_grants;
    logic [31:0]       stat_cpu_stalls;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[128];
    logic [31:0] mem_model[128];

    dmem_port_arbiter #(
        .DMEM_DEPTH  (128),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_re     (cpu_re),
        .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_dout(cpu_rd_dout),
        .cpu_we     (cpu_we),
        .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_din (cpu_wr_din),
        .cpu_wr_strb(cpu_wr_strb),
        .cpu_stall  (cpu_stall),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_strb   (dma_strb),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_din (mem_wr_din),
        .mem_we     (mem_we),
        .mem_wr_strb(mem_wr_strb),
        .mem_rd_dout(mem_rd_dout)
`ifdef ARB_STATS_EN
        ,
        .stat_dma_grants(stat_dma_grants),
        .stat_cpu_stalls(stat_cpu_stalls)
`endif
    );

    always #5 clk = ~clk;

    // data_mem stand-in: asynchronous read, posedge full-word write
    assign mem_rd_dout = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_wr_addr] <= mem_wr_din;
    end

    task automatic inputs_idle();
        cpu_re = 0; cpu_rd_addr = '0; cpu_we = 0; cpu_wr_addr = '0;
        cpu_wr_din = '0; cpu_wr_strb = '0;
        dma_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_strb = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        inputs_idle();
        cpu_we = 1; cpu_wr_addr = 7'd127; cpu_wr_din = 32'h1234_5678;
        @(negedge clk); #1;
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", dma_rvalid); end
        checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dma_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL reset_mem_we got=%b exp=1", mem_we); end
        mem_model[127] = 32'h1234_5678;
        @(negedge clk);
        inputs_idle();
        rst = 1;
        #1;
        checks++; if (dma_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dma_ready); end
        @(negedge clk);
    endtask

    task automatic test_dma_write_read();
        dma_valid = 1; dma_we = 1; dma_addr = 7'd5; dma_wdata = 32'hDEAD_BEEF; dma_strb = 3'b010;
        #1;
        checks++; if (dma_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", dma_ready); end
        checks++; if (mem_we !== 1'b1 || mem_wr_addr !== 7'd5 || mem_wr_din !== 32'hDEAD_BEEF)
            begin failures++; $display("FAIL wr_port got we=%b addr=%0d din=%h exp we=1 addr=5 din=deadbeef", mem_we, mem_wr_addr, mem_wr_din); end
        checks++; if (mem_wr_strb !== 3'b010) begin failures++; $display("FAIL wr_strb got=%b exp=010", mem_wr_strb); end
        mem_model[5] = 32'hDEAD_BEEF;
        @(negedge clk);
        dma_we = 0;
        #1;
        checks++; if (dma_ready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_accept got ready=%b we=%b exp ready=1 we=0", dma_ready, mem_we); end
        exp_q.push_back(mem_model[5]);
        @(negedge clk);
        dma_valid = 0;
        #1;
        checks++; if (dma_rvalid !== 1'b1 || dma_ready !== 1'b0) begin failures++; $display("FAIL rd_resp got rvalid=%b ready=%b exp rvalid=1 ready=0", dma_rvalid, dma_ready); end
        if (dma_rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL rd_data unexpected response got=%h", dma_rdata); end
            else begin
                logic [31:0] e = exp_q.pop_front();
                if (dma_rdata !== e) begin failures++; $display("FAIL rd_data got=%h exp=%h", dma_rdata, e); end
            end
        end
        @(negedge clk); #1;
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", dma_rvalid); end
        exp_q.delete();
    endtask

    task automatic test_starvation();
        int ready_seen = 0;
        cpu_re = 1; cpu_rd_addr = 7'd10;
        dma_valid = 1; dma_we = 1; dma_addr = 7'd20; dma_wdata = 32'h2020_2020; dma_strb = 3'b111;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (i == 0) begin
                checks++; if (cpu_rd_dout !== mem_model[10]) begin failures++; $display("FAIL starve_passthru got=%h exp=%h", cpu_rd_dout, mem_model[10]); end
            end
            if (dma_ready === 1'b1) ready_seen++;
            if (i == 8) begin
                checks++; if (dma_ready !== 1'b1 || cpu_stall !== 1'b1) begin failures++; $display("FAIL starve_grant got ready=%b stall=%b exp 1 1", dma_ready, cpu_stall); end
                checks++; if (mem_we !== 1'b1 || mem_wr_addr !== 7'd20 || mem_rd_addr !== 7'd20) begin failures++; $display("FAIL starve_port got we=%b wa=%0d ra=%0d exp 1 20 20", mem_we, mem_wr_addr, mem_rd_addr); end
                mem_model[20] = 32'h2020_2020;
            end else if (cpu_stall !== 1'b0) begin
                checks++; failures++; $display("FAIL starve_early_stall cycle=%0d got=1 exp=0", i);
            end
            @(negedge clk);
        end
        checks++; if (ready_seen != 1) begin failures++; $display("FAIL starve_ready_count got=%0d exp=1", ready_seen); end
        dma_valid = 0;
        #1;
        checks++; if (cpu_stall !== 1'b0 || mem_rd_addr !== 7'd10) begin failures++; $display("FAIL starve_after got stall=%b ra=%0d exp 0 10", cpu_stall, mem_rd_addr); end
        @(negedge clk);
        inputs_idle();
    endtask

    task automatic read_sequence(input string name, input logic [ADDR_W-1:0] a0,
                                 input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        logic [ADDR_W-1:0] addrs[3];
        int idx = 0;
        logic acc;
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        dma_valid = 1; dma_we = 0; dma_addr = addrs[0];
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (dma_ready !== (c % 2 == 0) || dma_rvalid !== (c % 2 == 1)) begin
                failures++; $display("FAIL %s_handshake cycle=%0d got ready=%b rvalid=%b exp ready=%0d rvalid=%0d", name, c, dma_ready, dma_rvalid, c % 2 == 0, c % 2 == 1);
            end
            if (dma_rvalid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL %s_data unexpected response got=%h", name, dma_rdata); end
                else begin
                    logic [31:0] e = exp_q.pop_front();
                    if (dma_rdata !== e) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, dma_rdata, e); end
                end
            end
            acc = dma_valid && dma_ready;
            if (acc) exp_q.push_back(mem_model[dma_addr]);
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) dma_addr = addrs[idx];
                else dma_valid = 0;
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL %s_drain got=%0d pending exp=0", name, exp_q.size()); end
        exp_q.delete();
        inputs_idle();
    endtask

    task automatic test_collision();
        cpu_we = 1; cpu_wr_addr = 7'd3; cpu_wr_din = 32'h3000_0000; cpu_wr_strb = 3'b111;
        dma_valid = 1; dma_we = 1; dma_addr = 7'd40; dma_wdata = 32'h4040_4040; dma_strb = 3'b001;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (i < 8) begin
                if (mem_wr_addr !== 7'd3 || cpu_stall !== 1'b0) begin checks++; failures++; $display("FAIL coll_cpu cycle=%0d got wa=%0d stall=%b exp 3 0", i, mem_wr_addr, cpu_stall); end
                mem_model[3] = cpu_wr_din;
                @(negedge clk);
                cpu_wr_din = 32'h3000_0000 + 32'(i + 1);
            end else begin
                checks++; if (mem_wr_addr !== 7'd40 || mem_wr_din !== 32'h4040_4040 || mem_wr_strb !== 3'b001 || cpu_stall !== 1'b1)
                    begin failures++; $display("FAIL coll_grant got wa=%0d din=%h strb=%b stall=%b exp 40 40404040 001 1", mem_wr_addr, mem_wr_din, mem_wr_strb, cpu_stall); end
                mem_model[40] = 32'h4040_4040;
                @(negedge clk);
            end
        end
        dma_valid = 0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_wr_addr !== 7'd3 || mem_wr_din !== 32'h3000_0008 || cpu_stall !== 1'b0)
            begin failures++; $display("FAIL coll_retry got we=%b wa=%0d din=%h stall=%b exp 1 3 30000008 0", mem_we, mem_wr_addr, mem_wr_din, cpu_stall); end
        mem_model[3] = 32'h3000_0008;
        @(negedge clk);
        inputs_idle();
        read_sequence("coll_readback", 7'd40, 7'd3, 7'd20);
    endtask

    task automatic test_back_to_back();
        read_sequence("b2b", 7'd50, 7'd51, 7'd5);
    endtask

    task automatic test_reset_mid_resp();
        dma_valid = 1; dma_we = 0; dma_addr = 7'd52;
        @(negedge clk);
        dma_valid = 0;
        #1;
        checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL mid_resp_setup got=%b exp=1", dma_rvalid); end
        rst = 0;
        #1;
        checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0 || cpu_stall !== 1'b0)
            begin failures++; $display("FAIL mid_resp_reset got rvalid=%b rdata=%h stall=%b exp 0 0 0", dma_rvalid, dma_rdata, cpu_stall); end
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        checks++; if (dma_ready !== 1'b1 || dma_rvalid !== 1'b0 || dma_rdata !== 32'h0)
            begin failures++; $display("FAIL mid_resp_release got ready=%b rvalid=%b rdata=%h exp 1 0 0", dma_ready, dma_rvalid, dma_rdata); end
        @(negedge clk); #1;
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL mid_resp_dropped got=%b exp=0", dma_rvalid); end
        @(negedge clk);
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        rst = 0;
        @(negedge clk);
        rst = 1;
        checks++; if (stat_dma_grants !== 32'h0 || stat_cpu_stalls !== 32'h0)
            begin failures++; $display("FAIL stats_reset got g=%0d s=%0d exp 0 0", stat_dma_grants, stat_cpu_stalls); end
        for (int r = 0; r < 2; r++) begin
            cpu_re = 1; cpu_rd_addr = 7'd11;
            dma_valid = 1; dma_we = 1; dma_addr = 7'd21; dma_wdata = 32'h2121_2121;
            repeat (9) @(negedge clk);
            dma_valid = 0;
            @(negedge clk);
        end
        mem_model[21] = 32'h2121_2121;
        inputs_idle();
        #1;
        checks++; if (stat_dma_grants !== 32'd2 || stat_cpu_stalls !== 32'd2)
            begin failures++; $display("FAIL stats_count got g=%0d s=%0d exp 2 2", stat_dma_grants, stat_cpu_stalls); end
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]       = 32'hA500_0000 + 32'(i);
            mem_model[i] = 32'hA500_0000 + 32'(i);
        end
        test_reset();
        test_dma_write_read();
        test_starvation();
        test_collision();
        test_back_to_back();
        test_reset_mid_resp();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
